// File: rtl/av_config_seq.sv
// av_config_seq: boots audio codec / video decoder registers from an external ROM over I2C, then serves runtime writes.
// Build option: define AVCONF_VIDEO_EN to include video-decoder entries (index >= VID_START) in the boot walk.
module av_config_seq #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned I2C_FREQ  = 20000,
  parameter int unsigned ROM_DEPTH = 50,
  parameter int unsigned ADDR_W    = 6,
  parameter logic [7:0]  AUD_ADDR  = 8'h34,
  parameter logic [7:0]  VID_ADDR  = 8'h40,
  parameter int unsigned VID_START = 10,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              CLOCK_50,
  input  logic              iRST_N,
  output logic              FPGA_I2C_SCLK,
  inout  wire               FPGA_I2C_SDAT,
  output logic [ADDR_W-1:0] rom_index,
  input  logic [15:0]       rom_data,
  input  logic              wr_req,
  input  logic [7:0]        wr_dev,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_index
);

  localparam int unsigned DIV   = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`ifdef AVCONF_VIDEO_EN
  localparam int unsigned BOOT_LEN = ROM_DEPTH;
`else
  localparam int unsigned BOOT_LEN = (VID_START < ROM_DEPTH) ? VID_START : ROM_DEPTH;
`endif
  localparam int unsigned LAST = BOOT_LEN - 1;

  typedef enum logic [3:0] {IDLE, LOAD, START, BYTE, ACK, STOP, GAP, NEXT, READY} state_t;

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_div;
  logic [1:0]          r_ph, w_ph_nxt;
  logic [2:0]          r_bit, w_bit_nxt;
  logic [1:0]          r_byte, w_byte_nxt;
  logic [ADDR_W-1:0]   r_rom_index, w_rom_index_nxt;
  logic [RTY_W-1:0]    r_retry, w_retry_nxt;
  logic                r_nack, w_nack_nxt;
  logic                r_rt, w_rt_nxt;
  logic [7:0]          r_dev, w_dev_nxt;
  logic [15:0]         r_pay, w_pay_nxt;
  logic                r_done, w_done_nxt;
  logic                r_error, w_error_nxt;
  logic [ADDR_W-1:0]   r_err_index, w_err_index_nxt;
  logic                r_wr_ack, w_wr_ack_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_scl, w_scl_nxt;
  logic                r_sda_oe, w_sda_oe_nxt;
  logic [7:0]          w_byte;
  logic                w_tick;
  logic                w_sda_in;

  assign w_tick        = (r_div == DIV_W'(DIV - 1));
  assign w_sda_in      = FPGA_I2C_SDAT;
  assign FPGA_I2C_SCLK = r_scl;
  assign FPGA_I2C_SDAT = r_sda_oe ? 1'b0 : 1'bz;
  assign rom_index     = r_rom_index;
  assign wr_ack        = r_wr_ack;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign err_index     = r_err_index;

  // Quarter-bit tick generator
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) r_div <= '0;
    else         r_div <= w_tick ? '0 : r_div + DIV_W'(1);
  end

  // State and registered outputs
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= IDLE;
      r_ph        <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_rom_index <= '0;
      r_retry     <= '0;
      r_nack      <= 1'b0;
      r_rt        <= 1'b0;
      r_dev       <= '0;
      r_pay       <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_wr_ack    <= 1'b0;
      r_busy      <= 1'b0;
      r_scl       <= 1'b1;
      r_sda_oe    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ph        <= w_ph_nxt;
      r_bit       <= w_bit_nxt;
      r_byte      <= w_byte_nxt;
      r_rom_index <= w_rom_index_nxt;
      r_retry     <= w_retry_nxt;
      r_nack      <= w_nack_nxt;
      r_rt        <= w_rt_nxt;
      r_dev       <= w_dev_nxt;
      r_pay       <= w_pay_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_err_index <= w_err_index_nxt;
      r_wr_ack    <= w_wr_ack_nxt;
      r_busy      <= w_busy_nxt;
      r_scl       <= w_scl_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ph_nxt        = r_ph;
    w_bit_nxt       = r_bit;
    w_byte_nxt      = r_byte;
    w_rom_index_nxt = r_rom_index;
    w_retry_nxt     = r_retry;
    w_nack_nxt      = r_nack;
    w_rt_nxt        = r_rt;
    w_dev_nxt       = r_dev;
    w_pay_nxt       = r_pay;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
    w_err_index_nxt = r_err_index;
    w_wr_ack_nxt    = 1'b0;
    w_scl_nxt       = 1'b1;
    w_sda_oe_nxt    = 1'b0;
    w_byte          = r_dev;

    if (w_tick) begin
      w_ph_nxt = r_ph + 2'd1;
      case (r_state)
        IDLE: begin
          w_state_nxt = LOAD;
          w_ph_nxt    = '0;
        end
        LOAD: begin
          if (!r_rt) begin
            w_dev_nxt = (r_rom_index < ADDR_W'(VID_START)) ? AUD_ADDR : VID_ADDR;
            w_pay_nxt = rom_data;
          end
          w_nack_nxt  = 1'b0;
          w_state_nxt = START;
          w_ph_nxt    = '0;
        end
        START: if (r_ph == 2'd3) begin
          w_state_nxt = BYTE;
          w_byte_nxt  = '0;
          w_bit_nxt   = 3'd7;
        end
        BYTE: if (r_ph == 2'd3) begin
          if (r_bit == 3'd0) w_state_nxt = ACK;
          else               w_bit_nxt   = r_bit - 3'd1;
        end
        ACK: begin
          if (r_ph == 2'd2 && w_sda_in) w_nack_nxt = 1'b1;
          if (r_ph == 2'd3) begin
            if (r_byte == 2'd2) w_state_nxt = STOP;
            else begin
              w_state_nxt = BYTE;
              w_byte_nxt  = r_byte + 2'd1;
              w_bit_nxt   = 3'd7;
            end
          end
        end
        STOP: if (r_ph == 2'd3) w_state_nxt = GAP;
        GAP: if (r_ph == 2'd3) begin
          if (r_nack && r_retry < RTY_W'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + RTY_W'(1);
            w_state_nxt = LOAD;
          end else begin
            // Either acknowledged or out of retries: the entry is finished
            if (r_nack) begin
              w_error_nxt = 1'b1;
              if (!r_error) w_err_index_nxt = r_rt ? '1 : r_rom_index;
            end
            w_retry_nxt = '0;
            if (r_rt) begin
              w_rt_nxt     = 1'b0;
              w_wr_ack_nxt = 1'b1;
              w_state_nxt  = READY;
            end else begin
              w_state_nxt = NEXT;
            end
          end
        end
        NEXT: begin
          w_ph_nxt    = '0;
          w_retry_nxt = '0;
          if (r_rom_index == ADDR_W'(LAST)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = READY;
          end else begin
            w_rom_index_nxt = r_rom_index + ADDR_W'(1);
            w_state_nxt     = LOAD;
          end
        end
        READY: begin
          w_ph_nxt = '0;
          if (wr_req) begin
            w_dev_nxt   = wr_dev;
            w_pay_nxt   = wr_data;
            w_rt_nxt    = 1'b1;
            w_retry_nxt = '0;
            w_state_nxt = LOAD;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    w_busy_nxt = (w_state_nxt == LOAD) || (w_state_nxt == START) || (w_state_nxt == BYTE) ||
                 (w_state_nxt == ACK)  || (w_state_nxt == STOP)  || (w_state_nxt == GAP);

    case (w_byte_nxt)
      2'd0:    w_byte = r_dev;
      2'd1:    w_byte = r_pay[15:8];
      default: w_byte = r_pay[7:0];
    endcase

    // Bus levels for the quarter-bit slot about to begin
    case (w_state_nxt)
      START: begin
        w_scl_nxt    = (w_ph_nxt < 2'd2);
        w_sda_oe_nxt = (w_ph_nxt != 2'd0);
      end
      BYTE: begin
        w_scl_nxt    = (w_ph_nxt == 2'd1) || (w_ph_nxt == 2'd2);
        w_sda_oe_nxt = !w_byte[w_bit_nxt];
      end
      ACK: begin
        w_scl_nxt    = (w_ph_nxt == 2'd1) || (w_ph_nxt == 2'd2);
        w_sda_oe_nxt = 1'b0;
      end
      STOP: begin
        w_scl_nxt    = (w_ph_nxt != 2'd0);
        w_sda_oe_nxt = (w_ph_nxt < 2'd2);
      end
      default: begin
        w_scl_nxt    = 1'b1;
        w_sda_oe_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_av_config_seq.sv
// tb_av_config_seq: I2C bus decoder + scripted slave against a frame scoreboard for av_config_seq.
// Honours AVCONF_VIDEO_EN to choose the expected boot length.
module tb_av_config_seq;

  localparam int unsigned CLK_FREQ  = 1000000;
  localparam int unsigned I2C_FREQ  = 62500;
  localparam int unsigned DIV       = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned ROM_DEPTH = 12;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned VID_START = 10;
`ifdef AVCONF_VIDEO_EN
  localparam int unsigned LAST = ROM_DEPTH - 1;
`else
  localparam int unsigned LAST = VID_START - 1;
`endif

  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       nack;
  } frm_t;

  logic              CLOCK_50 = 1'b0;
  logic              iRST_N;
  wire               FPGA_I2C_SCLK;
  wire               FPGA_I2C_SDAT;
  logic [ADDR_W-1:0] rom_index;
  logic [15:0]       rom_data;
  logic              wr_req;
  logic [7:0]        wr_dev;
  logic [15:0]       wr_data;
  logic              wr_ack;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] err_index;
  logic              slv_drv = 1'b0;

  frm_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  assign FPGA_I2C_SDAT = slv_drv ? 1'b0 : 1'bz;
  pullup (FPGA_I2C_SDAT);

  function automatic logic [15:0] rom_val(input int i);
    logic [8:0] d;
    if (i == 10) return 16'h1500;
    d = 9'((i * 37 + 24) % 512);
    return {7'(i), d};
  endfunction

  assign rom_data = rom_val(int'(rom_index));

  av_config_seq #(
    .CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .ROM_DEPTH(ROM_DEPTH), .ADDR_W(ADDR_W),
    .AUD_ADDR(8'h34), .VID_ADDR(8'h40), .VID_START(VID_START), .MAX_RETRY(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .iRST_N(iRST_N), .FPGA_I2C_SCLK(FPGA_I2C_SCLK), .FPGA_I2C_SDAT(FPGA_I2C_SDAT),
    .rom_index(rom_index), .rom_data(rom_data), .wr_req(wr_req), .wr_dev(wr_dev), .wr_data(wr_data),
    .wr_ack(wr_ack), .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_frm(input logic [7:0] d, input logic [15:0] p, input logic n);
    frm_t f;
    f.dev = d; f.hi = p[15:8]; f.lo = p[7:0]; f.nack = n;
    sb.push_back(f);
  endtask

  // Entry 3 is refused on every attempt, entry 5 only on its first attempt
  task automatic push_boot();
    logic [7:0] d;
    for (int i = 0; i <= int'(LAST); i++) begin
      d = (i < int'(VID_START)) ? 8'h34 : 8'h40;
      if (i == 3) repeat (4) push_frm(d, rom_val(i), 1'b1);
      else if (i == 5) begin
        push_frm(d, rom_val(i), 1'b1);
        push_frm(d, rom_val(i), 1'b0);
      end else push_frm(d, rom_val(i), 1'b0);
    end
  endtask

  // Bus decoder and slave responder
  logic       p_scl = 1'b1, p_sda = 1'b1;
  bit         in_frm = 1'b0, first_frm = 1'b1;
  int         bitc = 0, bytec = 0, cyc = 0, last_rise = 0;
  logic [7:0] sh = '0;
  logic [7:0] fb [3];
  frm_t       e;

  always @(negedge CLOCK_50) begin
    cyc++;
    if (!iRST_N) begin
      in_frm = 1'b0; slv_drv = 1'b0; bitc = 0; bytec = 0;
    end else if (FPGA_I2C_SCLK && p_scl && p_sda && !FPGA_I2C_SDAT) begin
      in_frm = 1'b1; bitc = 0; bytec = 0;
      fb[0] = '0; fb[1] = '0; fb[2] = '0;
      chk("busy_at_start", 32'(busy), 32'd1);
    end else if (in_frm && FPGA_I2C_SCLK && p_scl && !p_sda && FPGA_I2C_SDAT) begin
      in_frm = 1'b0;
      if (sb.size() == 0) begin
        chk("frame_unexpected", {8'(bytec), fb[0], fb[1], fb[2]}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("frame", {8'(bytec), fb[0], fb[1], fb[2]}, {8'd3, e.dev, e.hi, e.lo});
      end
    end else if (in_frm && FPGA_I2C_SCLK && !p_scl) begin
      if (bitc < 8) begin
        sh = {sh[6:0], FPGA_I2C_SDAT};
        if (first_frm && bytec == 0 && bitc == 1) begin
          chk("scl_period", 32'(cyc - last_rise), 32'(4 * DIV));
          first_frm = 1'b0;
        end
        last_rise = cyc;
      end
      bitc++;
    end else if (in_frm && !FPGA_I2C_SCLK && p_scl) begin
      if (bitc == 8) begin
        if (bytec < 3) fb[bytec] = sh;
        slv_drv = !(bytec == 2 && sb.size() != 0 && sb[0].nack);
      end else if (bitc == 9) begin
        slv_drv = 1'b0;
        bitc = 0;
        bytec++;
      end
    end
    p_scl = FPGA_I2C_SCLK;
    p_sda = FPGA_I2C_SDAT;
  end

  // wr_ack must be exactly one cycle wide
  int ackw = 0;
  always @(negedge CLOCK_50) begin
    if (iRST_N) begin
      if (wr_ack) ackw++;
      else if (ackw != 0) begin
        chk("wr_ack_width", 32'(ackw), 32'd1);
        ackw = 0;
      end
    end
  end

  initial begin
    int  acks;
    bit  hit;
    iRST_N = 1'b0; wr_req = 1'b0; wr_dev = '0; wr_data = '0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_scl", 32'(FPGA_I2C_SCLK), 32'd1);
    chk("rst_sda", 32'(FPGA_I2C_SDAT), 32'd1);
    chk("rst_rom_index", 32'(rom_index), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_index", 32'(err_index), 32'd0);

    // First boot, interrupted part-way through entry 7
    push_boot();
    iRST_N = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20000 && !hit; i++) begin
      @(negedge CLOCK_50);
      if (rom_index == ADDR_W'(7) && busy) hit = 1'b1;
    end
    chk("reach_index7", 32'(hit), 32'd1);
    repeat (100) @(negedge CLOCK_50);
    iRST_N = 1'b0;
    #1;
    chk("midrst_scl", 32'(FPGA_I2C_SCLK), 32'd1);
    chk("midrst_sda", 32'(FPGA_I2C_SDAT), 32'd1);
    chk("midrst_rom_index", 32'(rom_index), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    sb.delete();
    repeat (3) @(negedge CLOCK_50);

    // Full boot with a runtime write already pending; the write must follow the boot
    push_boot();
    push_frm(8'h34, 16'h0479, 1'b0);
    wr_dev = 8'h34; wr_data = 16'h0479; wr_req = 1'b1;
    iRST_N = 1'b1;
    acks = 0;
    for (int i = 0; i < 40000 && acks < 3; i++) begin
      @(negedge CLOCK_50);
      if (wr_ack) begin
        acks++;
        chk("done_at_ack", 32'(done), 32'd1);
        if (acks < 3) push_frm(8'h34, 16'h0479, 1'b0);
        else wr_req = 1'b0;
      end
    end
    chk("rt_ack_count", 32'(acks), 32'd3);
    repeat (2000) @(negedge CLOCK_50);
    chk("sb_empty_boot", 32'(sb.size()), 32'd0);
    chk("boot_done", 32'(done), 32'd1);
    chk("boot_error", 32'(error), 32'd1);
    chk("boot_err_index", 32'(err_index), 32'd3);
    chk("boot_rom_index_hold", 32'(rom_index), 32'(LAST));
    chk("idle_busy", 32'(busy), 32'd0);

    // Runtime write refused on every attempt: abandoned after retries, first error index kept
    repeat (4) push_frm(8'h40, 16'hABCD, 1'b1);
    wr_dev = 8'h40; wr_data = 16'hABCD; wr_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10000 && !hit; i++) begin
      @(negedge CLOCK_50);
      if (wr_ack) begin
        hit = 1'b1;
        wr_req = 1'b0;
      end
    end
    chk("rt_nack_ack", 32'(hit), 32'd1);
    repeat (300) @(negedge CLOCK_50);
    chk("sb_empty_rt", 32'(sb.size()), 32'd0);
    chk("rt_error", 32'(error), 32'd1);
    chk("rt_err_index_first", 32'(err_index), 32'd3);
    chk("end_scl", 32'(FPGA_I2C_SCLK), 32'd1);
    chk("end_sda", 32'(FPGA_I2C_SDAT), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
